mem_stage_lsu: RTL

- Memory-access stage that sits directly downstream of the EX/MEM pipeline register.
- Issues loads and stores to a variable-latency data-memory port using a req/ack handshake.
- Aligns, masks and sign/zero-extends load data, and stalls the upstream pipeline while an access is outstanding.
- Registers its results into the MEM/WB boundary, so its outputs feed the writeback mux directly.

---
 rtl/mem_stage_lsu.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEM pipeline stage: load/store unit with req/ack data-memory port
//
// Purpose: issues loads/stores from the EX/MEM register to a variable-latency
// data memory, stalls upstream while an access is outstanding, aligns and
// extends load data, and registers the writeback value into the MEM/WB boundary.
//
// Ports:
//   clk, reset                  clock (rising edge), asynchronous active-high reset
//   MEM_*                       EX/MEM pipeline register fields (address/ALU result,
//                               store data, rd, reg_write, result_src, mem_write, funct3)
//   dmem_req/we/addr/wdata/be   data-memory request (combinational from MEM_* and state)
//   dmem_ack/rdata              data-memory completion and read word
//   mem_stall                   holds PC, IF/ID, ID/EX and EX/MEM while high
//   WB_result/rd/reg_write      registered writeback fields
//   misalign_err, bus_err       one-cycle registered error pulses

module mem_stage_lsu #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] MEM_alu_result,
  input  logic [31:0] MEM_write_data,
  input  logic [4:0]  MEM_rd,
  input  logic        MEM_reg_write,
  input  logic        MEM_result_src,
  input  logic        MEM_mem_write,
  input  logic [2:0]  MEM_funct3,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic [31:0] WB_result,
  output logic [4:0]  WB_rd,
  output logic        WB_reg_write,
  output logic        misalign_err,
  output logic        bus_err
);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  localparam logic [7:0] LP_LIMIT = 8'(TIMEOUT_CYCLES);

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_next;

  logic        w_mem_op;
  logic        w_illegal;
  logic        w_misalign;
  logic        w_bad;
  logic        w_good;
  logic        w_req;
  logic        w_timeout;
  logic        w_complete;
  logic [1:0]  w_off;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_result;

  logic [31:0] r_wb_result;
  logic [4:0]  r_wb_rd;
  logic        r_wb_reg_write;
  logic        r_misalign_err;
  logic        r_bus_err;

  assign w_off    = MEM_alu_result[1:0];
  assign w_mem_op = MEM_result_src | MEM_mem_write;

  // Stores accept 000/001/010; loads additionally accept 100/101.
  always_comb begin
    w_illegal = 1'b0;
    if (MEM_mem_write)
      w_illegal = MEM_funct3[2] | (MEM_funct3[1:0] == 2'b11);
    else
      w_illegal = (MEM_funct3[1:0] == 2'b11) | (MEM_funct3 == 3'b110);
  end

  assign w_misalign = ((MEM_funct3[1:0] == 2'b01) & w_off[0]) |
                      ((MEM_funct3[1:0] == 2'b10) & (w_off != 2'b00));

  // A bad access is only judged in IDLE; in WAIT the inputs are frozen by the stall.
  assign w_bad  = (r_state == ST_IDLE) & w_mem_op & (w_illegal | w_misalign);
  assign w_good = w_mem_op & ~w_illegal & ~w_misalign;

  // Request datapath: lanes are replicated so memory can pick any byte lane via be.
  assign dmem_addr = {MEM_alu_result[31:2], 2'b00};
  assign dmem_we   = MEM_mem_write;

  always_comb begin
    dmem_wdata = MEM_write_data;
    dmem_be    = 4'b1111;
    case (MEM_funct3[1:0])
      2'b00: begin
        dmem_wdata = {4{MEM_write_data[7:0]}};
        dmem_be    = 4'b0001 << w_off;
      end
      2'b01: begin
        dmem_wdata = {2{MEM_write_data[15:0]}};
        dmem_be    = 4'b0011 << {w_off[1], 1'b0};
      end
      default: begin
        dmem_wdata = MEM_write_data;
        dmem_be    = 4'b1111;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_req        = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_good) begin
          w_req = 1'b1;
          if (!dmem_ack) begin
            w_state_next = ST_WAIT;
            w_cnt_next   = 8'd1;
          end
        end
      end
      ST_WAIT: begin
        // Ack is checked before the limit so a last-cycle ack still succeeds.
        if (dmem_ack) begin
          w_req        = 1'b1;
          w_state_next = ST_IDLE;
          w_cnt_next   = 8'd0;
        end else if (r_cnt >= LP_LIMIT) begin
          w_timeout    = 1'b1;
          w_state_next = ST_IDLE;
          w_cnt_next   = 8'd0;
        end else begin
          w_req      = 1'b1;
          w_cnt_next = r_cnt + 8'd1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = 8'd0;
      end
    endcase
  end

  // Reset drops the handshake combinationally so an in-flight access is abandoned.
  assign dmem_req  = w_req & ~reset;
  assign mem_stall = w_req & ~dmem_ack & ~reset;

  // Completion: acked access, or a non-memory op passing through IDLE.
  assign w_complete = (w_req & dmem_ack) | ((r_state == ST_IDLE) & ~w_mem_op);

  always_comb begin
    case (w_off)
      2'b00:   w_byte = dmem_rdata[7:0];
      2'b01:   w_byte = dmem_rdata[15:8];
      2'b10:   w_byte = dmem_rdata[23:16];
      default: w_byte = dmem_rdata[31:24];
    endcase
    w_half = w_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (MEM_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {24'd0, w_byte};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = dmem_rdata;
    endcase
    w_result = MEM_result_src ? w_load : MEM_alu_result;
  end

  // Anything other than a completion (stall, bad access, timeout) is a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wb_result    <= 32'd0;
      r_wb_rd        <= 5'd0;
      r_wb_reg_write <= 1'b0;
      r_misalign_err <= 1'b0;
      r_bus_err      <= 1'b0;
    end else begin
      r_misalign_err <= w_bad;
      r_bus_err      <= w_timeout;
      if (w_complete) begin
        r_wb_result    <= w_result;
        r_wb_rd        <= MEM_rd;
        r_wb_reg_write <= MEM_reg_write;
      end else begin
        r_wb_reg_write <= 1'b0;
      end
    end
  end

  assign WB_result    = r_wb_result;
  assign WB_rd        = r_wb_rd;
  assign WB_reg_write = r_wb_reg_write;
  assign misalign_err = r_misalign_err;
  assign bus_err      = r_bus_err;

endmodule
